spi_lcd_frame_seq: RTL
======================

Name: spi_lcd_frame_seq

Overview:
- Frame-write sequencer that drives the SPI PHY for a MIPI-DBI (ST7789/ILI9341-class) panel over SPI.
- On `start`, sends the column/page window commands (0x2A, 0x2B) and RAMWR (0x2C), then streams W*H RGB565 pixels as hi/lo byte pairs.
- Pixels come from an upstream valid/ready source (preprocessing pipeline output).
- Sits between the image pipeline and the SPI PHY. Drives the PHY byte, enable, CS, DC and prescaler inputs; watches the PHY dataClk byte strobe.

Parameters:
- PRESCALER, 16'd5, value driven on phy_prescaler (SCK half-period in masterClk cycles); must be >= 2.

Ports:
- masterClk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse, begin frame; ignored while busy.
- x0, x1  in  16 each  column window, inclusive; sampled on accepted start.
- y0, y1  in  16 each  page window, inclusive; sampled on accepted start.
- pix_data  in  16  RGB565 pixel.
- pix_valid  in  1  pixel available.
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at frame end.
- phy_data_clk  in  1  PHY byte strobe; rises when the PHY latches the presented byte.
- phy_output_data  out  8  byte presented to the PHY.
- phy_enable_spi  out  1  PHY enableSPI.
- phy_enable_cs  out  1  PHY enableCS.
- phy_enable_dc  out  1  PHY enableDC; 1 = command byte (DC low on wire).
- phy_prescaler  out  16  constant PRESCALER.

Behaviour:
- Reset (synchronous, rst high at posedge): state IDLE, busy=0, done=0, pix_ready=0, phy_output_data=8'h00, all phy_enable_*=0, pixel buffer empty, counters 0.
- Load event: phy_data_clk registered once per cycle; load = cur && !prev. A load means the PHY has taken the presented byte. On the following posedge the controller updates its presentation to the next slot. Byte period >= 16 cycles, so there is ample margin.
- Slot types (phy_enable_spi, phy_enable_cs, phy_enable_dc):
  - CMD slot: 1,1,1.
  - DATA slot: 1,1,0.
  - IDLE slot: 0,0,0; PHY holds CS high, MOSI=1.
- Accepted start (IDLE && start):
  - Latch window.
  - Compute npix = (x1-x0+1)*(y1-y0+1), 32-bit unsigned.
  - If x1<x0 or y1<y0: no transfer; done pulses the next cycle; stay IDLE.
  - Otherwise busy=1 and present header byte 0 immediately.
- HDR state: 11-byte header, index 0..10: 2A, x0[15:8], x0[7:0], x1[15:8], x1[7:0], 2B, y0[15:8], y0[7:0], y1[15:8], y1[7:0], 2C.
  - Indices 0, 5, 10 are CMD slots; the rest are DATA slots.
  - Each load advances the index. The load of index 10 moves to PIX_HI.
- Pixel buffer: one entry.
  - pix_ready = busy && buffer empty; asserted from header start so the first pixel prefetches.
  - A handshake fills the buffer.
- PIX_HI:
  - When a new slot must be presented and the buffer is full: present pix[15:8] as a DATA slot, copy pix[7:0] into lo_reg, free the buffer.
  - If the buffer is empty: present an IDLE slot (underflow) and retry at the next load.
  - The load of the HI byte moves to PIX_LO.
- PIX_LO:
  - Present lo_reg as a DATA slot.
  - On its load, increment the pixel count. If count==npix, present IDLE and go FLUSH; else go PIX_HI.
- FLUSH: on the next load (IDLE byte latched, CS high), done=1 for one cycle, busy=0, go IDLE.
- Simultaneous handshake and load in the same cycle: the buffer fill and the slot decision both use the pre-edge buffer state; a pixel filled in that cycle is used at the next load.
- rst mid-frame: immediate return to reset values. The PHY's already-latched byte finishes under PHY control; the next frame starts from HDR index 0.

Optional Feature:
- UNDERFLOW_CNT_EN defined:
  - Adds output underflow_cnt[15:0].
  - Counts IDLE slots inserted in PIX_HI for lack of a pixel; saturates at 16'hFFFF.
  - Cleared on rst and on accepted start.
- Not defined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset with rst high 3 cycles -> all outputs at reset values; phy_prescaler=5; later start pulses while rst is high are ignored.
- Window (0,0)-(0,0), pix_valid held with 16'hF800, bench uses the real SPI PHY with prescaler 5 -> wire bytes 2A 00 00 00 00 2B 00 00 00 00 2C F8 00, with DC low only on 2A, 2B, 2C; then CS high, done pulses once, busy falls.
- Window (2,3)-(3,4), pixels 0x1111, 0x2222, 0x3333, 0x4444 -> header 2A 00 02 00 03 2B 00 03 00 04 2C, then 11 11 22 22 33 33 44 44; exactly 4 handshakes.
- Same window, pix_valid withheld for 3 byte periods before pixel 2 -> 3 IDLE slots (CS high) between 11 11 and 22 22; data order intact; underflow_cnt=3 when UNDERFLOW_CNT_EN is defined.
- start with x0=5, x1=4 -> no CS activity, done pulses 1 cycle later, pix_ready stays 0.
- rst asserted after the 6th pixel byte of a 2x2 frame, then a new start -> IDLE; the new frame begins with 2A and carries the full 8 pixel bytes.

Source files
------------

// File: rtl/spi_lcd_frame_seq.sv
// rtl/spi_lcd_frame_seq.sv - MIPI-DBI window/RAMWR frame sequencer feeding an SPI PHY byte interface.
// Optional UNDERFLOW_CNT_EN adds underflow_cnt (IDLE slots inserted while waiting for a pixel).
module spi_lcd_frame_seq #(
    parameter logic [15:0] PRESCALER = 16'd5
) (
    input  logic        masterClk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] x0,
    input  logic [15:0] x1,
    input  logic [15:0] y0,
    input  logic [15:0] y1,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        busy,
    output logic        done,
    input  logic        phy_data_clk,
    output logic [7:0]  phy_output_data,
    output logic        phy_enable_spi,
    output logic        phy_enable_cs,
    output logic        phy_enable_dc,
    output logic [15:0] phy_prescaler
`ifdef UNDERFLOW_CNT_EN
    ,
    output logic [15:0] underflow_cnt
`endif
);
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_PIX_HI, S_PIX_LO, S_FLUSH} state_t;

    localparam logic [2:0] SLOT_CMD  = 3'b111;
    localparam logic [2:0] SLOT_DATA = 3'b110;
    localparam logic [2:0] SLOT_IDLE = 3'b000;

    state_t      state, state_n;
    logic [15:0] wx0, wx1, wy0, wy1;
    logic [31:0] npix, pix_cnt, cnt_n;
    logic [3:0]  idx, idx_n, hdr_sel;
    logic [7:0]  hdr_byte, data_n, lo_reg, lo_n;
    logic [2:0]  slot, slot_n;
    logic        clk_cur, clk_prev, load;
    logic        buf_full;
    logic [15:0] buf_data;
    logic        done_n, take_hi, consume, uf_inc, accept;

    assign load          = clk_cur && !clk_prev;
    assign busy          = (state != S_IDLE);
    assign pix_ready     = busy && !buf_full;
    assign phy_prescaler = PRESCALER;
    assign {phy_enable_spi, phy_enable_cs, phy_enable_dc} = slot;
    assign hdr_sel       = idx + 4'd1;

    always_comb begin
        hdr_byte = 8'h2A;
        case (hdr_sel)
            4'd1:    hdr_byte = wx0[15:8];
            4'd2:    hdr_byte = wx0[7:0];
            4'd3:    hdr_byte = wx1[15:8];
            4'd4:    hdr_byte = wx1[7:0];
            4'd5:    hdr_byte = 8'h2B;
            4'd6:    hdr_byte = wy0[15:8];
            4'd7:    hdr_byte = wy0[7:0];
            4'd8:    hdr_byte = wy1[15:8];
            4'd9:    hdr_byte = wy1[7:0];
            4'd10:   hdr_byte = 8'h2C;
            default: hdr_byte = 8'h2A;
        endcase
    end

    // Every transition that presents a new slot happens on load, except the first header byte.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = pix_cnt;
        data_n  = phy_output_data;
        slot_n  = slot;
        lo_n    = lo_reg;
        done_n  = 1'b0;
        take_hi = 1'b0;
        consume = 1'b0;
        uf_inc  = 1'b0;
        accept  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (x1 < x0 || y1 < y0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = S_HDR;
                        idx_n   = 4'd0;
                        cnt_n   = 32'd0;
                        data_n  = 8'h2A;
                        slot_n  = SLOT_CMD;
                    end
                end
            end
            S_HDR: begin
                if (load) begin
                    if (idx == 4'd10) begin
                        state_n = S_PIX_HI;
                        take_hi = 1'b1;
                    end else begin
                        idx_n  = hdr_sel;
                        data_n = hdr_byte;
                        slot_n = (hdr_sel == 4'd5 || hdr_sel == 4'd10) ? SLOT_CMD : SLOT_DATA;
                    end
                end
            end
            S_PIX_HI: begin
                // A DATA slot here is the HI byte just latched; an IDLE slot was an underflow.
                if (load) begin
                    if (slot == SLOT_DATA) begin
                        state_n = S_PIX_LO;
                        data_n  = lo_reg;
                        slot_n  = SLOT_DATA;
                    end else begin
                        take_hi = 1'b1;
                    end
                end
            end
            S_PIX_LO: begin
                if (load) begin
                    cnt_n = pix_cnt + 32'd1;
                    if (cnt_n == npix) begin
                        state_n = S_FLUSH;
                        data_n  = 8'h00;
                        slot_n  = SLOT_IDLE;
                    end else begin
                        state_n = S_PIX_HI;
                        take_hi = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (load) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (take_hi) begin
            if (buf_full) begin
                data_n  = buf_data[15:8];
                lo_n    = buf_data[7:0];
                slot_n  = SLOT_DATA;
                consume = 1'b1;
            end else begin
                data_n  = 8'h00;
                slot_n  = SLOT_IDLE;
                uf_inc  = 1'b1;
            end
        end
    end

    always_ff @(posedge masterClk) begin
        if (rst) begin
            state           <= S_IDLE;
            idx             <= 4'd0;
            pix_cnt         <= 32'd0;
            npix            <= 32'd0;
            wx0             <= 16'd0;
            wx1             <= 16'd0;
            wy0             <= 16'd0;
            wy1             <= 16'd0;
            phy_output_data <= 8'h00;
            slot            <= SLOT_IDLE;
            lo_reg          <= 8'h00;
            done            <= 1'b0;
            clk_cur         <= 1'b0;
            clk_prev        <= 1'b0;
            buf_full        <= 1'b0;
            buf_data        <= 16'd0;
        end else begin
            state           <= state_n;
            idx             <= idx_n;
            pix_cnt         <= cnt_n;
            phy_output_data <= data_n;
            slot            <= slot_n;
            lo_reg          <= lo_n;
            done            <= done_n;
            clk_cur         <= phy_data_clk;
            clk_prev        <= clk_cur;
            if (accept) begin
                wx0  <= x0;
                wx1  <= x1;
                wy0  <= y0;
                wy1  <= y1;
                npix <= ({16'd0, x1} - {16'd0, x0} + 32'd1) * ({16'd0, y1} - {16'd0, y0} + 32'd1);
            end
            // Fill needs an empty buffer and consume needs a full one, so they never collide.
            if (consume) begin
                buf_full <= 1'b0;
            end else if (pix_valid && pix_ready) begin
                buf_full <= 1'b1;
                buf_data <= pix_data;
            end
        end
    end

`ifdef UNDERFLOW_CNT_EN
    always_ff @(posedge masterClk) begin
        if (rst || accept) begin
            underflow_cnt <= 16'd0;
        end else if (uf_inc && underflow_cnt != 16'hFFFF) begin
            underflow_cnt <= underflow_cnt + 16'd1;
        end
    end
`else
    logic unused_uf;
    assign unused_uf = uf_inc;
`endif
endmodule
